trap_controller: RTL and testbench

//   Upstream feeder of the machine CSR file. Collects synchronous exception flags from the

---
 rtl/trap_controller.sv | 113 +++++++++++
 tb/tb_trap_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Trap controller: picks the highest-priority commit exception (or MRET), strobes the
// CSR file, flushes the pipeline for FLUSH_CYCLES and then hands a redirect to fetch.
module trap_controller #(
  parameter logic [31:0] MTVEC_ADDR   = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  exc_vec_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  output logic        trap_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] trap_cause_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        trap_next, flush_next, stall_next, valid_next;
  logic [31:0] trap_pc_next, cause_next, target_next;
  logic [31:0] prio_cause;

  // bit0 is the highest priority exception
  always_comb begin
    prio_cause = 32'd0;
    if (exc_vec_i[0])      prio_cause = 32'd0;
    else if (exc_vec_i[1]) prio_cause = 32'd2;
    else if (exc_vec_i[2]) prio_cause = 32'd3;
    else if (exc_vec_i[3]) prio_cause = 32'd11;
    else if (exc_vec_i[4]) prio_cause = 32'd4;
    else if (exc_vec_i[5]) prio_cause = 32'd6;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    trap_next    = 1'b0;
    trap_pc_next = trap_pc_o;
    cause_next   = trap_cause_o;
    flush_next   = 1'b0;
    valid_next   = 1'b0;
    target_next  = redirect_pc_o;
    case (state_reg)
      IDLE: begin
        if (exc_vec_i != 6'd0) begin
          trap_next    = 1'b1;
          trap_pc_next = exc_pc_i;
          cause_next   = prio_cause;
          target_next  = MTVEC_ADDR;
          cnt_next     = CNT_INIT;
          flush_next   = 1'b1;
          state_next   = FLUSH;
        end else if (mret_i) begin
          target_next  = mepc_i;
          cnt_next     = CNT_INIT;
          flush_next   = 1'b1;
          state_next   = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_reg == 4'd0) begin
          valid_next = 1'b1;
          state_next = REDIRECT;
        end else begin
          cnt_next   = cnt_reg - 4'd1;
          flush_next = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_valid_o && redirect_ready_i) state_next = IDLE;
        else                                      valid_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Outputs are registered, so stall reflects the state being entered
    stall_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= 4'd0;
      trap_o           <= 1'b0;
      trap_pc_o        <= 32'd0;
      trap_cause_o     <= 32'd0;
      flush_o          <= 1'b0;
      stall_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'd0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      trap_o           <= trap_next;
      trap_pc_o        <= trap_pc_next;
      trap_cause_o     <= cause_next;
      flush_o          <= flush_next;
      stall_o          <= stall_next;
      redirect_valid_o <= valid_next;
      redirect_pc_o    <= target_next;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: a vector table of single requests plus
// hand-written sequences for the long redirect wait and a mid-flush reset.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  exc_vec_i = '0;
  logic [31:0] exc_pc_i = '0;
  logic        mret_i = 1'b0;
  logic [31:0] mepc_i = '0;
  logic        trap_o;
  logic [31:0] trap_pc_o;
  logic [31:0] trap_cause_o;
  logic        flush_o;
  logic        stall_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  trap_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exc_vec_i        (exc_vec_i),
    .exc_pc_i         (exc_pc_i),
    .mret_i           (mret_i),
    .mepc_i           (mepc_i),
    .trap_o           (trap_o),
    .trap_pc_o        (trap_pc_o),
    .trap_cause_o     (trap_cause_o),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  exc;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] mepc;
    logic        exp_trap;
    logic [31:0] exp_cause;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".trap"},   {31'd0, trap_o}, 32'd0);
    check({tag, ".pc"},     trap_pc_o, 32'd0);
    check({tag, ".cause"},  trap_cause_o, 32'd0);
    check({tag, ".flush"},  {31'd0, flush_o}, 32'd0);
    check({tag, ".stall"},  {31'd0, stall_o}, 32'd0);
    check({tag, ".valid"},  {31'd0, redirect_valid_o}, 32'd0);
    check({tag, ".rpc"},    redirect_pc_o, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_vec_i = '0;
    exc_pc_i  = '0;
    mret_i    = 1'b0;
    mepc_i    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] last_pc;
    logic [31:0] last_cause;

    //            exc        mret  pc            mepc          trap  cause   target
    vecs[0] = '{6'b000010, 1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'd2,  32'h100};
    vecs[1] = '{6'b111100, 1'b0, 32'h0000_0080, 32'h0,        1'b1, 32'd3,  32'h100};
    vecs[2] = '{6'b110000, 1'b0, 32'h0000_0084, 32'h0,        1'b1, 32'd4,  32'h100};
    vecs[3] = '{6'b000000, 1'b1, 32'h0000_0088, 32'h0000_0204, 1'b0, 32'd0,  32'h204};
    vecs[4] = '{6'b001000, 1'b1, 32'h0000_0090, 32'h0000_0300, 1'b1, 32'd11, 32'h100};
    vecs[5] = '{6'b111111, 1'b0, 32'h0000_0044, 32'h0,        1'b1, 32'd0,  32'h100};
    vecs[6] = '{6'b100000, 1'b0, 32'h0000_00a0, 32'h0,        1'b1, 32'd6,  32'h100};
    vecs[7] = '{6'b101000, 1'b0, 32'h0000_00a4, 32'h0,        1'b1, 32'd11, 32'h100};

    // Reset with random inputs
    for (int k = 0; k < 3; k++) begin
      exc_vec_i        = 6'($urandom);
      exc_pc_i         = $urandom;
      mret_i           = 1'($urandom);
      mepc_i           = $urandom;
      redirect_ready_i = 1'($urandom);
      tick();
    end
    check_all_zero("reset_held");
    @(negedge clk);
    clear_inputs();
    redirect_ready_i = 1'b0;
    rst_n = 1'b1;
    tick();
    check_all_zero("reset_released");
    $display("reset: outputs checked while held and after release");

    last_pc    = 32'd0;
    last_cause = 32'd0;
    for (int i = 0; i < 8; i++) begin
      exc_vec_i = vecs[i].exc;
      mret_i    = vecs[i].mret;
      exc_pc_i  = vecs[i].pc;
      mepc_i    = vecs[i].mepc;
      tick();                               // cycle N+1
      clear_inputs();
      check("v.trap_n1", {31'd0, trap_o}, {31'd0, vecs[i].exp_trap});
      if (vecs[i].exp_trap) begin
        last_pc    = vecs[i].pc;
        last_cause = vecs[i].exp_cause;
      end
      check("v.trap_pc",    trap_pc_o, last_pc);
      check("v.trap_cause", trap_cause_o, last_cause);
      check("v.flush_n1",   {31'd0, flush_o}, 32'd1);
      check("v.stall_n1",   {31'd0, stall_o}, 32'd1);
      check("v.valid_n1",   {31'd0, redirect_valid_o}, 32'd0);
      tick();                               // cycle N+2
      check("v.trap_n2",    {31'd0, trap_o}, 32'd0);
      check("v.flush_n2",   {31'd0, flush_o}, 32'd1);
      check("v.valid_n2",   {31'd0, redirect_valid_o}, 32'd0);
      tick();                               // cycle N+3
      check("v.flush_n3",   {31'd0, flush_o}, 32'd0);
      check("v.valid_n3",   {31'd0, redirect_valid_o}, 32'd1);
      check("v.rpc_n3",     redirect_pc_o, vecs[i].exp_target);
      check("v.stall_n3",   {31'd0, stall_o}, 32'd1);
      redirect_ready_i = 1'b1;
      tick();                               // cycle N+4
      redirect_ready_i = 1'b0;
      check("v.valid_n4",   {31'd0, redirect_valid_o}, 32'd0);
      check("v.stall_n4",   {31'd0, stall_o}, 32'd0);
      check("v.flush_n4",   {31'd0, flush_o}, 32'd0);
      $display("vector %0d: exc=%b mret=%0d trap=%0d cause=%0d target=%h",
               i, vecs[i].exc, vecs[i].mret, trap_o, trap_cause_o, redirect_pc_o);
    end

    // Long redirect wait with a request arriving mid-wait
    exc_vec_i = 6'b000010;
    exc_pc_i  = 32'h0000_0048;
    tick();
    clear_inputs();
    check("w.trap", {31'd0, trap_o}, 32'd1);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      check("w.valid", {31'd0, redirect_valid_o}, 32'd1);
      check("w.rpc",   redirect_pc_o, 32'h100);
      check("w.stall", {31'd0, stall_o}, 32'd1);
      check("w.flush", {31'd0, flush_o}, 32'd0);
      check("w.trap",  {31'd0, trap_o}, 32'd0);
      if (k == 3) begin
        exc_vec_i = 6'b000100;
        exc_pc_i  = 32'h0000_0999;
        mret_i    = 1'b1;
        mepc_i    = 32'h0000_0777;
      end
      if (k == 4) clear_inputs();
      tick();
    end
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    check("w.valid_done", {31'd0, redirect_valid_o}, 32'd0);
    check("w.stall_done", {31'd0, stall_o}, 32'd0);
    tick();
    check("w.no_second_trap", {31'd0, trap_o}, 32'd0);
    check("w.cause_held",     trap_cause_o, 32'd2);
    check("w.pc_held",        trap_pc_o, 32'h48);
    $display("wait: 10-cycle stall with ignored request, cause=%0d", trap_cause_o);

    // Reset asserted in the second flush cycle
    exc_vec_i = 6'b000001;
    exc_pc_i  = 32'h0000_0050;
    tick();
    clear_inputs();
    check("r.trap", {31'd0, trap_o}, 32'd1);
    tick();
    check("r.flush2", {31'd0, flush_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("r.no_redirect", {30'd0, redirect_valid_o, trap_o}, 32'd0);
      check("r.idle",        {30'd0, stall_o, flush_o}, 32'd0);
    end
    $display("reset mid-flush: aborted, no redirect after release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
